// File: rtl/multi_debouncer.sv
// N-channel switch debouncer: per-channel 4-state qualification FSM with level, press and release ticks.
// Optional 2-flop input synchronizer compiled in with `define MULTI_DEBOUNCER_SYNC_EN.
module multi_debouncer #(
  parameter int N_CH      = 4,
  parameter int DB_CYCLES = 120
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [N_CH-1:0] en_i,
  input  logic [N_CH-1:0] sw_i,
  output logic [N_CH-1:0] db_level_o,
  output logic [N_CH-1:0] db_tick_o,
  output logic [N_CH-1:0] db_fall_o,
  output logic            any_tick_o
);

  localparam int CNT_W = $clog2(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_LOW       = 2'd0,
    ST_WAIT_HIGH = 2'd1,
    ST_HIGH      = 2'd2,
    ST_WAIT_LOW  = 2'd3
  } state_t;

  logic [N_CH-1:0] samp;

`ifdef MULTI_DEBOUNCER_SYNC_EN
  logic [N_CH-1:0] sync_q1;
  logic [N_CH-1:0] sync_q2;

  // Two-flop synchronizer; a disabled channel has its flops cleared
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q1 <= {N_CH{1'b0}};
      sync_q2 <= {N_CH{1'b0}};
    end else begin
      sync_q1 <= sw_i & en_i;
      sync_q2 <= sync_q1 & en_i;
    end
  end

  assign samp = sync_q2;
`else
  assign samp = sw_i;
`endif

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             level_q;
    logic             tick_q;
    logic             fall_q;

    // Per-channel qualification FSM; reset outranks enable, neither emits a fall tick
    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        state   <= ST_LOW;
        cnt     <= CNT_ZERO;
        level_q <= 1'b0;
        tick_q  <= 1'b0;
        fall_q  <= 1'b0;
      end else if (!en_i[k]) begin
        state   <= ST_LOW;
        cnt     <= CNT_ZERO;
        level_q <= 1'b0;
        tick_q  <= 1'b0;
        fall_q  <= 1'b0;
      end else begin
        tick_q <= 1'b0;
        fall_q <= 1'b0;
        case (state)
          ST_LOW: begin
            level_q <= 1'b0;
            if (samp[k]) begin
              state <= ST_WAIT_HIGH;
              cnt   <= CNT_ONE;
            end else begin
              cnt <= CNT_ZERO;
            end
          end
          ST_WAIT_HIGH: begin
            if (!samp[k]) begin
              state <= ST_LOW;
              cnt   <= CNT_ZERO;
            end else if (cnt == CNT_LAST) begin
              state   <= ST_HIGH;
              cnt     <= CNT_ZERO;
              level_q <= 1'b1;
              tick_q  <= 1'b1;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          ST_HIGH: begin
            level_q <= 1'b1;
            if (!samp[k]) begin
              state <= ST_WAIT_LOW;
              cnt   <= CNT_ONE;
            end else begin
              cnt <= CNT_ZERO;
            end
          end
          ST_WAIT_LOW: begin
            if (samp[k]) begin
              state <= ST_HIGH;
              cnt   <= CNT_ZERO;
            end else if (cnt == CNT_LAST) begin
              state   <= ST_LOW;
              cnt     <= CNT_ZERO;
              level_q <= 1'b0;
              fall_q  <= 1'b1;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          default: begin
            state   <= ST_LOW;
            cnt     <= CNT_ZERO;
            level_q <= 1'b0;
          end
        endcase
      end
    end

    assign db_level_o[k] = level_q;
    assign db_tick_o[k]  = tick_q;
    assign db_fall_o[k]  = fall_q;
  end

  assign any_tick_o = |(db_tick_o | db_fall_o);

endmodule

// File: tb/tb_multi_debouncer.sv
// Directed self-checking bench for multi_debouncer (N_CH=4, DB_CYCLES=120); follows MULTI_DEBOUNCER_SYNC_EN.
module tb_multi_debouncer;

  localparam int N_CH      = 4;
  localparam int DB_CYCLES = 120;
`ifdef MULTI_DEBOUNCER_SYNC_EN
  localparam int L = 2;
`else
  localparam int L = 0;
`endif

  logic            clk;
  logic            rst_n;
  logic [N_CH-1:0] en;
  logic [N_CH-1:0] sw;
  logic [N_CH-1:0] level;
  logic [N_CH-1:0] tick;
  logic [N_CH-1:0] fall;
  logic            any;

  int n_checks = 0;
  int n_fail   = 0;
  int tick_total [N_CH];
  int fall_total [N_CH];

  multi_debouncer #(.N_CH(N_CH), .DB_CYCLES(DB_CYCLES)) dut (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .sw_i(sw),
    .db_level_o(level), .db_tick_o(tick), .db_fall_o(fall), .any_tick_o(any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < N_CH; i++) begin
      tick_total[i] = 0;
      fall_total[i] = 0;
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < N_CH; i++) begin
      tick_total[i] = tick_total[i] + int'(tick[i]);
      fall_total[i] = fall_total[i] + int'(fall[i]);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Call right after driving the new level at a negedge
  task automatic expect_rise(input logic [N_CH-1:0] mask, input string tag);
    cycles(DB_CYCLES - 1 + L);
    chk({tag, "_early_tick"}, 32'(tick & mask), 32'd0);
    chk({tag, "_early_level"}, 32'(level & mask), 32'd0);
    chk({tag, "_early_any"}, 32'(any), 32'd0);
    cycles(1);
    chk({tag, "_tick"}, 32'(tick & mask), 32'(mask));
    chk({tag, "_level"}, 32'(level & mask), 32'(mask));
    chk({tag, "_any"}, 32'(any), 32'd1);
    cycles(1);
    chk({tag, "_tick_once"}, 32'(tick & mask), 32'd0);
    chk({tag, "_any_once"}, 32'(any), 32'd0);
  endtask

  task automatic expect_fall(input logic [N_CH-1:0] mask, input string tag);
    cycles(DB_CYCLES - 1 + L);
    chk({tag, "_early_fall"}, 32'(fall & mask), 32'd0);
    chk({tag, "_early_level"}, 32'(level & mask), 32'(mask));
    cycles(1);
    chk({tag, "_fall"}, 32'(fall & mask), 32'(mask));
    chk({tag, "_level"}, 32'(level & mask), 32'd0);
    chk({tag, "_any"}, 32'(any), 32'd1);
    cycles(1);
    chk({tag, "_fall_once"}, 32'(fall & mask), 32'd0);
  endtask

  initial begin
    int t0;
    int f0;
    int w;

    rst_n = 1'b0;
    en    = 4'hF;
    sw    = 4'h0;
    cycles(3);
    chk("reset_level", 32'(level), 32'd0);
    chk("reset_tick", 32'(tick), 32'd0);
    chk("reset_fall", 32'(fall), 32'd0);
    chk("reset_any", 32'(any), 32'd0);
    rst_n = 1'b1;
    cycles(3);

    // Clean press and release on channel 0
    sw[0] = 1'b1;
    expect_rise(4'b0001, "press0");
    chk("press0_others_quiet", 32'(level & 4'b1110), 32'd0);
    cycles(240 - DB_CYCLES - L - 1);
    sw[0] = 1'b0;
    expect_fall(4'b0001, "release0");
    cycles(3);
    chk("press0_tick_count", 32'(tick_total[0]), 32'd1);
    chk("release0_fall_count", 32'(fall_total[0]), 32'd1);
    chk("ch123_no_ticks", 32'(tick_total[1] + tick_total[2] + tick_total[3]), 32'd0);

    // Bounce rejection on channel 1
    t0 = tick_total[1];
    for (int i = 0; i < 200; i++) begin
      sw[1] = ~sw[1];
      w = int'($urandom_range(119, 12));
      cycles(w);
    end
    chk("bounce_no_tick", 32'(tick_total[1] - t0), 32'd0);
    chk("bounce_level_low", 32'(level[1]), 32'd0);
    sw[1] = 1'b1;
    cycles(DB_CYCLES + L + 3);
    chk("bounce_hold_tick", 32'(tick_total[1] - t0), 32'd1);
    chk("bounce_hold_level", 32'(level[1]), 32'd1);
    sw[1] = 1'b0;
    cycles(DB_CYCLES + L + 3);
    chk("bounce_release_level", 32'(level[1]), 32'd0);

    // Boundary pulse widths on channel 3
    t0 = tick_total[3];
    f0 = fall_total[3];
    sw[3] = 1'b1;
    cycles(DB_CYCLES - 1);
    sw[3] = 1'b0;
    cycles(DB_CYCLES + L + 10);
    chk("short_pulse_no_tick", 32'(tick_total[3] - t0), 32'd0);
    chk("short_pulse_level", 32'(level[3]), 32'd0);
    sw[3] = 1'b1;
    cycles(DB_CYCLES);
    sw[3] = 1'b0;
    cycles(L + 1);
    chk("exact_pulse_level", 32'(level[3]), 32'd1);
    cycles(3);
    chk("exact_pulse_tick", 32'(tick_total[3] - t0), 32'd1);
    cycles(DB_CYCLES + 5);
    chk("exact_pulse_fall", 32'(fall_total[3] - f0), 32'd1);
    chk("exact_pulse_level_low", 32'(level[3]), 32'd0);

    // All four channels rise together
    sw = 4'hF;
    expect_rise(4'hF, "simul");

    // Disable channel 2 while HIGH, then re-enable with the switch still pressed
    f0 = fall_total[2];
    t0 = tick_total[2];
    cycles(5);
    en[2] = 1'b0;
    cycles(1);
    chk("disable_level", 32'(level), 32'b1011);
    chk("disable_no_fall", 32'(fall), 32'd0);
    cycles(10);
    en[2] = 1'b1;
    expect_rise(4'b0100, "reenable");
    cycles(3);
    chk("disable_fall_count", 32'(fall_total[2] - f0), 32'd0);
    chk("reenable_tick_count", 32'(tick_total[2] - t0), 32'd1);

    sw = 4'h0;
    expect_fall(4'hF, "release_all");
    cycles(5);

    // Reset mid WAIT_HIGH aborts qualification, then a fresh press follows
    t0 = tick_total[0];
    sw[0] = 1'b1;
    cycles(60 + L);
    rst_n = 1'b0;
    cycles(1);
    chk("rst_wait_level", 32'(level), 32'd0);
    chk("rst_wait_tick", 32'(tick), 32'd0);
    rst_n = 1'b1;
    expect_rise(4'b0001, "post_reset");
    cycles(3);
    chk("rst_wait_tick_count", 32'(tick_total[0] - t0), 32'd1);

    // Reset while HIGH drops the level with no fall tick
    f0 = fall_total[0];
    rst_n = 1'b0;
    cycles(1);
    chk("rst_high_level", 32'(level[0]), 32'd0);
    chk("rst_high_fall", 32'(fall[0]), 32'd0);
    rst_n = 1'b1;
    sw[0] = 1'b0;
    cycles(DB_CYCLES + L + 5);
    chk("rst_high_fall_count", 32'(fall_total[0] - f0), 32'd0);
    chk("final_any", 32'(any), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
